// File: rtl/dma_host_responder_if.sv
// Host-side DMA channel bundle: mem_ctrl is the master, the local-RAM responder is the slave.
interface dma_host_responder_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int SIZE_WIDTH = 43,
   parameter int MEM_AW     = 10
);
   logic                  rd_go;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [SIZE_WIDTH-1:0] rd_size;
   logic                  rd_en;
   logic [511:0]          rd_data;
   logic                  empty;
   logic                  rd_done;
   logic                  wr_go;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [SIZE_WIDTH-1:0] wr_size;
   logic                  wr_en;
   logic [511:0]          wr_data;
   logic                  full;
   logic                  wr_done;
   logic                  stall_rd;
   logic                  ld_we;
   logic [MEM_AW-1:0]     ld_addr;
   logic [511:0]          ld_data;
   logic [1:0]            err;

   modport master (
      output rd_go, rd_addr, rd_size, rd_en,
      input  rd_data, empty, rd_done,
      output wr_go, wr_addr, wr_size, wr_en, wr_data,
      input  full, wr_done,
      output stall_rd, ld_we, ld_addr, ld_data,
      input  err
   );

   modport slave (
      input  rd_go, rd_addr, rd_size, rd_en,
      output rd_data, empty, rd_done,
      input  wr_go, wr_addr, wr_size, wr_en, wr_data,
      output full, wr_done,
      input  stall_rd, ld_we, ld_addr, ld_data,
      output err
   );
endinterface

// File: rtl/dma_host_responder.sv
// Local-RAM stand-in for the host DMA: FWFT read FIFO filled from RAM, write FIFO drained into RAM.
//
// state    | meaning
// S_IDLE   | waiting for go; done flag holds the outcome of the last transfer
// S_ACTIVE | transfer running; counters compare against the latched size
module dma_host_responder #(
   parameter int ADDR_WIDTH = 64,
   parameter int SIZE_WIDTH = 43,
   parameter int MEM_AW     = 10,
   parameter int FIFO_DEPTH = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   dma_host_responder_if.slave bus
);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam int LINES = 1 << MEM_AW;

   typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} ch_state_t;

   logic [511:0]          mem [LINES];
   logic [511:0]          ram_q;

   ch_state_t             rd_state, rd_state_nxt;
   logic [SIZE_WIDTH-1:0] rd_size_q, rd_issued, rd_popped;
   logic [MEM_AW-1:0]     rd_line;
   logic                  rd_vld, rd_accept, rd_issue, rd_pop, rd_finish, rd_done_q;
   logic [511:0]          rf_mem [FIFO_DEPTH];
   logic [PW-1:0]         rf_wp, rf_rp;
   logic [CW-1:0]         rf_cnt;
   logic                  rf_empty;

   ch_state_t             wr_state, wr_state_nxt;
   logic [SIZE_WIDTH-1:0] wr_size_q, wr_pushed, wr_committed;
   logic [MEM_AW-1:0]     wr_line;
   logic                  wr_accept, wr_push, wr_drain, wr_finish, wr_done_q;
   logic [511:0]          wf_mem [FIFO_DEPTH];
   logic [PW-1:0]         wf_wp, wf_rp;
   logic [CW-1:0]         wf_cnt;
   logic                  wf_full;

   logic [1:0]            err_q;
   logic                  unused_addr_bits;

   assign rf_empty = (rf_cnt == '0);
   assign wf_full  = (wf_cnt == CW'(FIFO_DEPTH));
   assign rd_pop   = bus.rd_en && !rf_empty;
   // A FIFO entry left over at the reset edge must not reach RAM.
   assign wr_drain = rst_n && (wf_cnt != '0);

   assign bus.empty   = rf_empty;
   assign bus.rd_data = rf_empty ? '0 : rf_mem[rf_rp];
   assign bus.full    = wf_full;
   assign bus.rd_done = rd_done_q;
   assign bus.wr_done = wr_done_q;
   assign bus.err     = err_q;

   assign unused_addr_bits = ^{bus.rd_addr[5:0], bus.rd_addr[ADDR_WIDTH-1:MEM_AW+6],
                               bus.wr_addr[5:0], bus.wr_addr[ADDR_WIDTH-1:MEM_AW+6]};

   always_ff @(posedge clk) begin
      if (!rst_n) rd_state <= S_IDLE;
      else        rd_state <= rd_state_nxt;
   end

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         S_IDLE:   if (bus.rd_go && bus.rd_size != '0) rd_state_nxt = S_ACTIVE;
         S_ACTIVE: if (rd_popped == rd_size_q) rd_state_nxt = S_IDLE;
         default:  rd_state_nxt = S_IDLE;
      endcase
   end

   // In-flight RAM read counts against FIFO room so the fill never overruns.
   always_comb begin
      rd_accept = 1'b0;
      rd_issue  = 1'b0;
      rd_finish = 1'b0;
      case (rd_state)
         S_IDLE:   rd_accept = bus.rd_go;
         S_ACTIVE: begin
            rd_issue  = !bus.stall_rd && (rd_issued < rd_size_q) &&
                        ((rf_cnt + CW'(rd_vld)) < CW'(FIFO_DEPTH));
            rd_finish = (rd_popped == rd_size_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) wr_state <= S_IDLE;
      else        wr_state <= wr_state_nxt;
   end

   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         S_IDLE:   if (bus.wr_go && bus.wr_size != '0) wr_state_nxt = S_ACTIVE;
         S_ACTIVE: if (wr_committed == wr_size_q) wr_state_nxt = S_IDLE;
         default:  wr_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      wr_accept = 1'b0;
      wr_push   = 1'b0;
      wr_finish = 1'b0;
      case (wr_state)
         S_IDLE:   wr_accept = bus.wr_go;
         S_ACTIVE: begin
            wr_push   = bus.wr_en && !wf_full && (wr_pushed < wr_size_q);
            wr_finish = (wr_committed == wr_size_q);
         end
         default: ;
      endcase
   end

   // Non-blocking read next to the write gives old data on a same-line collision.
   always_ff @(posedge clk) begin
      if (rd_issue) ram_q <= mem[rd_line];
      if (wr_drain)       mem[wr_line]     <= wf_mem[wf_rp];
      else if (bus.ld_we) mem[bus.ld_addr] <= bus.ld_data;
   end

   always_ff @(posedge clk) begin
      if (rd_vld)  rf_mem[rf_wp] <= ram_q;
      if (wr_push) wf_mem[wf_wp] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_size_q <= '0;
         rd_issued <= '0;
         rd_popped <= '0;
         rd_line   <= '0;
         rd_vld    <= 1'b0;
         rd_done_q <= 1'b0;
         rf_wp     <= '0;
         rf_rp     <= '0;
         rf_cnt    <= '0;
      end else begin
         rd_vld <= rd_issue;
         if (rd_accept) begin
            rd_size_q <= bus.rd_size;
            rd_issued <= '0;
            rd_popped <= '0;
            rd_line   <= bus.rd_addr[MEM_AW+5:6];
            rd_done_q <= (bus.rd_size == '0);
         end else begin
            if (rd_issue) begin
               rd_issued <= rd_issued + SIZE_WIDTH'(1);
               rd_line   <= rd_line + MEM_AW'(1);
            end
            if (rd_pop)    rd_popped <= rd_popped + SIZE_WIDTH'(1);
            if (rd_finish) rd_done_q <= 1'b1;
         end
         if (rd_vld) rf_wp <= rf_wp + PW'(1);
         if (rd_pop) rf_rp <= rf_rp + PW'(1);
         rf_cnt <= rf_cnt + CW'(rd_vld) - CW'(rd_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_size_q    <= '0;
         wr_pushed    <= '0;
         wr_committed <= '0;
         wr_line      <= '0;
         wr_done_q    <= 1'b0;
         wf_wp        <= '0;
         wf_rp        <= '0;
         wf_cnt       <= '0;
      end else begin
         if (wr_accept) begin
            wr_size_q    <= bus.wr_size;
            wr_pushed    <= '0;
            wr_committed <= '0;
            wr_line      <= bus.wr_addr[MEM_AW+5:6];
            wr_done_q    <= (bus.wr_size == '0);
         end else begin
            if (wr_push) wr_pushed <= wr_pushed + SIZE_WIDTH'(1);
            if (wr_drain) begin
               wr_committed <= wr_committed + SIZE_WIDTH'(1);
               wr_line      <= wr_line + MEM_AW'(1);
            end
            if (wr_finish) wr_done_q <= 1'b1;
         end
         if (wr_push)  wf_wp <= wf_wp + PW'(1);
         if (wr_drain) wf_rp <= wf_rp + PW'(1);
         wf_cnt <= wf_cnt + CW'(wr_push) - CW'(wr_drain);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 2'b00;
      end else begin
         if (bus.rd_en && rf_empty) err_q[0] <= 1'b1;
         if (bus.wr_en && !wr_push) err_q[1] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dma_host_responder.sv
// Bench for dma_host_responder with a 16-line RAM: reference memory image plus expected read streams.
module tb_dma_host_responder;
   localparam int AW    = 64;
   localparam int SW    = 43;
   localparam int MAW   = 4;
   localparam int DEPTH = 8;
   localparam int LINES = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dma_host_responder_if #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .MEM_AW(MAW)) bus ();

   dma_host_responder #(
      .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .MEM_AW(MAW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [63:0] addr;
      int          size;
      int          first;
   } rd_vec_t;

   int           n_vec = 0;
   int           n_bad = 0;
   logic [511:0] ref_mem [LINES];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic idle_inputs();
      bus.rd_go = 0; bus.rd_addr = '0; bus.rd_size = '0; bus.rd_en = 0;
      bus.wr_go = 0; bus.wr_addr = '0; bus.wr_size = '0; bus.wr_en = 0; bus.wr_data = '0;
      bus.stall_rd = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_data = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Pops lines start..size-1 of a stream beginning at RAM line 'first', then expects rd_done.
   task automatic drain(input string name, input int first, input int start, input int size,
                        input int en_pct, input int stall_pct);
      int got = start;
      int budget = 0;
      while (got < size && budget < 1000) begin
         bus.stall_rd = ($urandom_range(99) < stall_pct);
         bus.rd_en    = !bus.empty && ($urandom_range(99) < en_pct);
         if (bus.rd_en) begin
            check($sformatf("%s line%0d", name, got), bus.rd_data, ref_mem[(first + got) % LINES]);
            got++;
         end
         tick();
         budget++;
      end
      bus.rd_en = 0;
      bus.stall_rd = 0;
      if (got < size) check({name, " timeout"}, 512'(got), 512'(size));
      for (int k = 0; k < 4 && !bus.rd_done; k++) tick();
      check({name, " rd_done"}, 512'(bus.rd_done), 512'(1));
      check({name, " empty after"}, 512'(bus.empty), 512'(1));
   endtask

   task automatic do_read(input string name, input logic [63:0] addr, input int size,
                          input int first, input int en_pct, input int stall_pct);
      bus.rd_addr = addr;
      bus.rd_size = SW'(size);
      bus.rd_go   = 1;
      tick();
      bus.rd_go   = 0;
      check({name, " empty at go+1"}, 512'(bus.empty), 512'(1));
      drain(name, first, 0, size, en_pct, stall_pct);
   endtask

   task automatic do_write(input string name, input logic [63:0] addr, input int size,
                           input int en_pct);
      int first = int'(addr[9:6]);
      int pushed = 0;
      int budget = 0;
      logic [511:0] d;
      bus.wr_addr = addr;
      bus.wr_size = SW'(size);
      bus.wr_go   = 1;
      tick();
      bus.wr_go   = 0;
      while (pushed < size && budget < 1000) begin
         if (!bus.full && $urandom_range(99) < en_pct) begin
            d = rnd512();
            bus.wr_en = 1;
            bus.wr_data = d;
            ref_mem[(first + pushed) % LINES] = d;
            pushed++;
         end else begin
            bus.wr_en = 0;
         end
         tick();
         budget++;
      end
      bus.wr_en = 0;
      for (int k = 0; k < 8 && !bus.wr_done; k++) tick();
      check({name, " wr_done"}, 512'(bus.wr_done), 512'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rd_vec_t tbl [5];
      logic [63:0] a;
      tbl = '{
         '{addr: 64'h0,   size: 4, first: 0},
         '{addr: 64'h3C0, size: 3, first: 15},
         '{addr: 64'h3E5, size: 2, first: 15},
         '{addr: 64'h400, size: 1, first: 0},
         '{addr: 64'h1A8, size: 5, first: 6}
      };

      do_reset();
      check("reset empty",   512'(bus.empty),   512'(1));
      check("reset full",    512'(bus.full),    512'(0));
      check("reset rd_data", bus.rd_data,       512'(0));
      check("reset rd_done", 512'(bus.rd_done), 512'(0));
      check("reset wr_done", 512'(bus.wr_done), 512'(0));
      check("reset err",     512'(bus.err),     512'(0));

      for (int i = 0; i < LINES; i++) begin
         bus.ld_we   = 1;
         bus.ld_addr = 4'(i);
         bus.ld_data = (i < 4) ? 512'(32'hA0 + i) : rnd512();
         ref_mem[i]  = bus.ld_data;
         tick();
      end
      bus.ld_we = 0;

      foreach (tbl[v]) do_read($sformatf("tbl%0d", v), tbl[v].addr, tbl[v].size, tbl[v].first, 100, 0);
      check("tbl err", 512'(bus.err), 512'(0));

      // Back-to-back write of three lines, with a backdoor load colliding with the first commit.
      bus.wr_addr = 64'h40; bus.wr_size = SW'(3); bus.wr_go = 1;
      tick();
      bus.wr_go = 0; bus.wr_en = 1; bus.wr_data = 512'hB0;
      tick();
      bus.wr_data = 512'hB1;
      bus.ld_we = 1; bus.ld_addr = 4'd12; bus.ld_data = 512'hDEAD;
      tick();
      bus.ld_we = 0; bus.wr_data = 512'hB2;
      tick();
      bus.wr_en = 0;
      check("t2 full", 512'(bus.full), 512'(0));
      tick();
      check("t2 wr_done early", 512'(bus.wr_done), 512'(0));
      tick();
      check("t2 wr_done", 512'(bus.wr_done), 512'(1));
      ref_mem[1] = 512'hB0; ref_mem[2] = 512'hB1; ref_mem[3] = 512'hB2;
      do_read("t2 readback", 64'h40, 3, 1, 100, 0);
      do_read("t2 ld dropped", 64'h300, 1, 12, 100, 0);

      // Stalled fill, ignored re-go, exact FIFO depth, then full drain.
      bus.stall_rd = 1; bus.rd_addr = 64'h0; bus.rd_size = SW'(16); bus.rd_go = 1;
      tick();
      for (int c = 0; c < 20; c++) begin
         bus.rd_go = (c == 5);
         if (c == 5) begin bus.rd_addr = 64'h200; bus.rd_size = SW'(2); end
         check("t3 stalled empty", 512'(bus.empty), 512'(1));
         tick();
      end
      bus.rd_go = 0; bus.stall_rd = 0;
      repeat (14) tick();
      check("t3 filled", 512'(bus.empty), 512'(0));
      bus.stall_rd = 1;
      for (int k = 0; k < DEPTH; k++) begin
         bus.rd_en = !bus.empty;
         check($sformatf("t3 head%0d", k), bus.rd_data, ref_mem[k]);
         tick();
      end
      bus.rd_en = 0;
      check("t3 held exactly 8", 512'(bus.empty), 512'(1));
      bus.stall_rd = 0;
      drain("t3 rest", 0, DEPTH, 16, 100, 0);

      // Reset after two of four lines are committed.
      bus.wr_addr = 64'h100; bus.wr_size = SW'(4); bus.wr_go = 1;
      tick();
      bus.wr_go = 0; bus.wr_en = 1; bus.wr_data = 512'hC0;
      tick();
      bus.wr_data = 512'hC1;
      tick();
      bus.wr_data = 512'hC2;
      tick();
      bus.wr_en = 0; rst_n = 0;
      tick();
      tick();
      check("t6 full",    512'(bus.full),    512'(0));
      check("t6 wr_done", 512'(bus.wr_done), 512'(0));
      check("t6 empty",   512'(bus.empty),   512'(1));
      check("t6 err",     512'(bus.err),     512'(0));
      rst_n = 1;
      tick();
      ref_mem[4] = 512'hC0; ref_mem[5] = 512'hC1;
      do_write("t6 rewrite", 64'h180, 4, 100);
      do_read("t6 readback", 64'h100, 6, 4, 100, 0);

      for (int it = 0; it < 30; it++) begin
         a = {$urandom, $urandom};
         if (it % 2 == 0) do_write($sformatf("rnd_wr%0d", it), a, int'($urandom_range(1, 8)), 60);
         else do_read($sformatf("rnd_rd%0d", it), a, int'($urandom_range(1, 20)), int'(a[9:6]), 70, 30);
      end

      // Zero-size read, pop while empty, over-long push.
      do_reset();
      bus.rd_addr = 64'h0; bus.rd_size = '0; bus.rd_go = 1;
      tick();
      bus.rd_go = 0;
      check("t5 rd_done", 512'(bus.rd_done), 512'(1));
      check("t5 empty",   512'(bus.empty),   512'(1));
      tick();
      check("t5 still empty", 512'(bus.empty), 512'(1));
      bus.rd_en = 1;
      tick();
      bus.rd_en = 0;
      check("t5 err pop", 512'(bus.err), 512'(2'b01));

      bus.wr_addr = 64'h280; bus.wr_size = SW'(2); bus.wr_go = 1;
      tick();
      bus.wr_go = 0; bus.wr_en = 1; bus.wr_data = 512'hE0;
      tick();
      bus.wr_data = 512'hE1;
      tick();
      bus.wr_data = 512'hE2;
      tick();
      bus.wr_en = 0;
      check("t4 err overpush", 512'(bus.err), 512'(2'b11));
      for (int k = 0; k < 8 && !bus.wr_done; k++) tick();
      check("t4 wr_done", 512'(bus.wr_done), 512'(1));
      ref_mem[10] = 512'hE0; ref_mem[11] = 512'hE1;
      do_read("t4 dropped", 64'h280, 3, 10, 100, 0);

      do_reset();
      bus.wr_en = 1; bus.wr_data = 512'hF0;
      tick();
      bus.wr_en = 0;
      check("t4 err idle push", 512'(bus.err), 512'(2'b10));
      tick();
      check("t4 idle full", 512'(bus.full), 512'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
